// File: rtl/score_pkg.sv
// score_pkg: shared state encoding and constants for the score_bcd converter.
package score_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int BCD_DIGITS = 4;
  localparam logic [15:0] DEC_MAX = 16'd9999;
  localparam int SHIFT_CNT = 16;
endpackage

// File: rtl/bcd_adj3.sv
// bcd_adj3: one-digit shift-and-add-3 adjust (d >= 5 ? d+3 : d).
module bcd_adj3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/score_bcd.sv
// score_bcd: sequential 16-bit binary to packed BCD converter, one bit per clock.
// Define SCORE_BCD_SAT_EN to clamp inputs above 9999 to 9999 instead of wrapping.
module score_bcd
  import score_pkg::*;
#(
  parameter int IN_W = 16
) (
  input  logic            cclk,
  input  logic            clr,
  input  logic            start,
  input  logic [IN_W-1:0] bin,
  output logic            busy,
  output logic            done,
  output logic [15:0]     bcd,
  output logic            ovf
);
  localparam int SCR_W = (BCD_DIGITS + 1) * 4;
  state_t state_q, state_d;
  logic [IN_W-1:0] sr_q, sr_d, load;
  logic [SCR_W-1:0] scr_q, scr_d, adj;
  logic [3:0] cnt_q, cnt_d;
  logic ovf_nx_q, ovf_nx_d, ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;
  logic [15:0] bcd_q, bcd_d;
  for (genvar i = 0; i <= BCD_DIGITS; i++) begin : g_adj
    bcd_adj3 u_adj (.d(scr_q[4*i +: 4]), .q(adj[4*i +: 4]));
  end
`ifdef SCORE_BCD_SAT_EN
  assign load = (bin > DEC_MAX) ? DEC_MAX : bin;
`else
  assign load = bin;
`endif
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    scr_d    = scr_q;
    cnt_d    = cnt_q;
    ovf_nx_d = ovf_nx_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        sr_d     = load;
        scr_d    = '0;
        cnt_d    = '0;
        ovf_nx_d = bin > DEC_MAX;
        state_d  = SHIFT;
      end
      SHIFT: begin
        {scr_d, sr_d} = {adj, sr_q} << 1;
        cnt_d = cnt_q + 4'd1;
        state_d = (cnt_q == 4'(SHIFT_CNT - 1)) ? DONE : SHIFT;
      end
      DONE: begin
        bcd_d   = scr_q[15:0];
        ovf_d   = ovf_nx_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge cclk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      scr_q    <= '0;
      cnt_q    <= '0;
      ovf_nx_q <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      scr_q    <= scr_d;
      cnt_q    <= cnt_d;
      ovf_nx_q <= ovf_nx_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;
endmodule
